// File: rtl/frequency_meter_100mhz_if.sv
// Measurement bus for frequency_meter_100mhz: control and signal in, results out.
interface frequency_meter_100mhz_if #(
    parameter int unsigned COUNT_WIDTH = 27
);
    logic                   Enable;
    logic                   Signal_in;
    logic [COUNT_WIDTH-1:0] Frequency;
    logic                   Valid;
    logic                   Overflow;
    logic                   Busy;

    // Side that drives the meter (board logic or testbench)
    modport master (
        output Enable,
        output Signal_in,
        input  Frequency,
        input  Valid,
        input  Overflow,
        input  Busy
    );

    // The meter itself
    modport slave (
        input  Enable,
        input  Signal_in,
        output Frequency,
        output Valid,
        output Overflow,
        output Busy
    );
endinterface

// File: rtl/frequency_meter_100mhz.sv
// Frequency meter: counts synchronized rising edges of Signal_in over back-to-back
// gate windows of GATE_CYCLES clocks and publishes each completed window's count.
module frequency_meter_100mhz #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned COUNT_WIDTH = 27
) (
    input  logic                      Clock_100MHz,
    input  logic                      Clear,
    frequency_meter_100mhz_if.slave   bus
);
    localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]      GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [GATE_W-1:0]      gate_q, gate_d;
    logic [COUNT_WIDTH-1:0] edge_q, edge_d;
    logic                   sat_q, sat_d;
    logic [COUNT_WIDTH-1:0] freq_q, freq_d;
    logic                   ovf_q, ovf_d;
    logic                   valid_q, valid_d;
    logic                   busy_q;

    logic sync1, sync2, prev;
    logic rise;
    logic at_max;
    logic sat_now;
    logic [COUNT_WIDTH-1:0] edge_plus;

    // Two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge Clock_100MHz or posedge Clear) begin
        if (Clear) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= bus.Signal_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    // Saturating increment of the edge counter; sat_now flags an increment lost at max
    always_comb begin
        at_max    = (edge_q == COUNT_MAX);
        edge_plus = at_max ? edge_q : (edge_q + COUNT_WIDTH'(1));
        sat_now   = rise & at_max;
    end

    // State, counters and result registers
    always_ff @(posedge Clock_100MHz or posedge Clear) begin
        if (Clear) begin
            state_q <= IDLE;
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            busy_q  <= (state_d == MEASURE);
        end
    end

    // Next-state and datapath: windows run back-to-back; Enable low discards the partial window
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                gate_d = '0;
                edge_d = '0;
                sat_d  = 1'b0;
                if (bus.Enable) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!bus.Enable) begin
                    state_d = IDLE;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else if (gate_q == GATE_LAST) begin
                    // A rise in the terminal cycle still belongs to the ending window
                    freq_d  = rise ? edge_plus : edge_q;
                    ovf_d   = sat_q | sat_now;
                    valid_d = 1'b1;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else begin
                    gate_d = gate_q + GATE_W'(1);
                    if (rise) begin
                        edge_d = edge_plus;
                    end
                    sat_d = sat_q | sat_now;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.Frequency = freq_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Valid     = valid_q;
    assign bus.Busy      = busy_q;

endmodule

// File: tb/tb_frequency_meter_100mhz.sv
// Testbench: two meters (wide and 4-bit counter) share stimulus; a window-level
// reference model predicts each completed window and a monitor checks every cycle.
module tb_frequency_meter_100mhz;
    localparam int unsigned G  = 100;
    localparam int unsigned WA = 27;
    localparam int unsigned WB = 4;

    logic clk = 1'b0;
    logic clear;
    logic enable;
    logic sig;

    always #5 clk = ~clk;

    frequency_meter_100mhz_if #(.COUNT_WIDTH(WA)) ifa ();
    frequency_meter_100mhz_if #(.COUNT_WIDTH(WB)) ifb ();

    assign ifa.Enable    = enable;
    assign ifa.Signal_in = sig;
    assign ifb.Enable    = enable;
    assign ifb.Signal_in = sig;

    frequency_meter_100mhz #(.GATE_CYCLES(G), .COUNT_WIDTH(WA)) dut_a (
        .Clock_100MHz (clk),
        .Clear        (clear),
        .bus          (ifa.slave)
    );

    frequency_meter_100mhz #(.GATE_CYCLES(G), .COUNT_WIDTH(WB)) dut_b (
        .Clock_100MHz (clk),
        .Clear        (clear),
        .bus          (ifb.slave)
    );

    typedef struct {
        longint unsigned freq;
        bit              ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int errors = 0;
    int checks = 0;

    // Reference model state: window occupancy and a true (unbounded) edge count
    bit     in_win   = 1'b0;
    int     pos      = 0;
    longint cnt      = 0;
    bit     h1       = 1'b0;
    bit     h2       = 1'b0;
    bit     h3       = 1'b0;
    bit     exp_busy = 1'b0;

    bit     sum_on  = 1'b0;
    longint sum_obs = 0;
    int     ph      = 0;

    function automatic exp_t clamp(longint c, int w);
        exp_t   e;
        longint mx;
        mx     = (longint'(1) << w) - 1;
        e.freq = (c > mx) ? longint'(mx) : c;
        e.ovf  = (c > mx);
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a rise is seen two sampled clocks after Signal_in goes high
    always @(posedge clk) begin
        bit r;
        if (clear) begin
            in_win = 1'b0;
            pos    = 0;
            cnt    = 0;
            h1     = 1'b0;
            h2     = 1'b0;
            h3     = 1'b0;
            qa.delete();
            qb.delete();
        end else begin
            r = h2 & ~h3;
            if (!in_win) begin
                if (enable) begin
                    in_win = 1'b1;
                    pos    = 0;
                    cnt    = 0;
                end
            end else if (!enable) begin
                in_win = 1'b0;
            end else begin
                cnt = cnt + longint'(r);
                if (pos == int'(G) - 1) begin
                    qa.push_back(clamp(cnt, WA));
                    qb.push_back(clamp(cnt, WB));
                    pos = 0;
                    cnt = 0;
                end else begin
                    pos++;
                end
            end
            h3 = h2;
            h2 = h1;
            h1 = sig;
        end
        exp_busy = in_win;
    end

    // Monitor: pops an expectation whenever one is due and checks held outputs every cycle
    initial begin
        longint unsigned held_fa, held_fb;
        bit held_oa, held_ob;
        exp_t e;
        held_fa = 0; held_fb = 0; held_oa = 0; held_ob = 0;
        forever begin
            @(posedge clk);
            #1;
            if (clear) begin
                held_fa = 0; held_fb = 0; held_oa = 0; held_ob = 0;
            end
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("valid_a", longint'(ifa.Valid), 1);
                held_fa = e.freq;
                held_oa = e.ovf;
                if (sum_on) sum_obs += longint'(e.freq);
            end else begin
                chk("valid_a", longint'(ifa.Valid), 0);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("valid_b", longint'(ifb.Valid), 1);
                held_fb = e.freq;
                held_ob = e.ovf;
            end else begin
                chk("valid_b", longint'(ifb.Valid), 0);
            end
            chk("freq_a", longint'(ifa.Frequency), longint'(held_fa));
            chk("ovf_a",  longint'(ifa.Overflow),  longint'(held_oa));
            chk("busy_a", longint'(ifa.Busy),      longint'(exp_busy));
            chk("freq_b", longint'(ifb.Frequency), longint'(held_fb));
            chk("ovf_b",  longint'(ifb.Overflow),  longint'(held_ob));
            chk("busy_b", longint'(ifb.Busy),      longint'(exp_busy));
        end
    end

    // Drive Signal_in for n cycles: per=0 random bits, otherwise period per with hi high cycles
    task automatic run(input int n, input int per, input int hi);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (per == 0) sig = 1'($urandom % 2);
            else          sig = ((ph % per) < hi);
            ph++;
        end
    endtask

    task automatic wait_pos(input int p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * int'(G); i++) begin
            @(negedge clk);
            if (in_win && pos == p) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_pos_timeout", 0, 1);
    endtask

    initial begin
        bit ok;
        int nv;
        clear  = 1'b1;
        enable = 1'b0;
        sig    = 1'b0;
        repeat (3) @(negedge clk);
        clear = 1'b0;

        // Clear mid-window with toggling input, then stay idle
        enable = 1'b1;
        run(150, 10, 5);
        clear = 1'b1;
        run(5, 2, 1);
        clear  = 1'b0;
        enable = 1'b0;
        run(3 * int'(G), 2, 1);

        // Basic count, max rate, saturation and recovery
        enable = 1'b1;
        ph = 0;
        run(600, 10, 5);
        run(500, 2, 1);
        run(500, 4, 2);
        run(500, 20, 10);

        // Abort at gate count 50, restore 7 cycles later
        wait_pos(50, ok);
        enable = 1'b0;
        run(7, 10, 5);
        enable = 1'b1;
        run(400, 10, 5);

        // Boundary attribution: rise on a terminal cycle, then on the first cycle of the next window
        sig = 1'b0;
        run(10, 1, 0);
        wait_pos(0, ok);
        sum_obs = 0;
        sum_on  = 1'b1;
        wait_pos(int'(G) - 3, ok);
        sig = 1'b1;
        @(negedge clk);
        sig = 1'b0;
        wait_pos(int'(G) - 2, ok);
        sig = 1'b1;
        @(negedge clk);
        sig = 1'b0;
        nv = 0;
        for (int i = 0; i < 6 * int'(G) && nv < 4; i++) begin
            @(negedge clk);
            if (ifa.Valid) nv++;
        end
        chk("boundary_windows", longint'(nv), 4);
        sum_on = 1'b0;
        chk("boundary_sum", sum_obs, 2);

        // Randomized periods, duty cycles, raw random bits and Enable drops
        for (int k = 0; k < 8; k++) begin
            int per, hi;
            per = int'($urandom_range(2, 40));
            hi  = int'($urandom_range(1, per - 1));
            if (k == 3) per = 0;
            run(int'($urandom_range(150, 400)), per, hi);
            if ($urandom % 3 == 0) begin
                enable = 1'b0;
                run(int'($urandom_range(1, 20)), per, hi);
                enable = 1'b1;
            end
        end

        enable = 1'b0;
        run(10, 1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
